// File: rtl/fifo66_beat_serializer.sv
// fifo66_beat_serializer: drains a FWFT FIFO of 66b words, drops bad
// headers, and streams the 64b payload as LSB-first valid/ready beats.
module fifo66_beat_serializer #(
  parameter int IN_WIDTH  = 66,
  parameter int OUT_WIDTH = 16,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 out_ctrl,
  output logic                 hdr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam int PW    = IN_WIDTH - 2;
  localparam int BEATS = PW / OUT_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PW-1:0]        r_payload;
  logic [PW-1:0]        w_payload_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_ctrl;
  logic                 w_ctrl_nxt;
  logic                 r_hdr_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [1:0]           w_hdr;
  logic                 w_legal;
  logic                 w_last;
  logic                 w_hs;
  logic                 w_pop;
  logic                 w_drop;

  assign w_hdr   = fifo_dout[IN_WIDTH-1 -: 2];
  assign w_legal = (w_hdr == 2'b01) || (w_hdr == 2'b10);
  assign w_last  = (r_idx == LAST_IDX);
  assign w_hs    = (r_state == SEND) && out_ready;

  // Refill on the cycle the last beat leaves, so words stream gap-free.
  assign w_pop  = reset_n && !fifo_empty &&
                  ((r_state == IDLE) || (w_hs && w_last));
  assign w_drop = w_pop && !w_legal;

  always_comb begin
    w_state_nxt   = r_state;
    w_payload_nxt = r_payload;
    w_idx_nxt     = r_idx;
    w_ctrl_nxt    = r_ctrl;
    unique case (r_state)
      IDLE: ;
      SEND: begin
        if (w_hs) begin
          w_payload_nxt = r_payload >> OUT_WIDTH;
          w_idx_nxt     = r_idx + 1'b1;
          if (w_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_ctrl_nxt  = 1'b0;
          end
        end
      end
      default: ;
    endcase
    if (w_pop && w_legal) begin
      w_state_nxt   = SEND;
      w_payload_nxt = fifo_dout[PW-1:0];
      w_idx_nxt     = '0;
      w_ctrl_nxt    = w_hdr[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_payload <= '0;
      r_idx     <= '0;
      r_ctrl    <= 1'b0;
      r_hdr_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_payload <= w_payload_nxt;
      r_idx     <= w_idx_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_hdr_err <= w_drop;
    end
  end

  // Clear wins over the old value, but a same-cycle error still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= w_drop ? ERR_CNT_W'(1) : '0;
    end else if (w_drop && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign fifo_rd_en = w_pop;
  assign out_valid  = (r_state == SEND);
  assign out_data   = r_payload[OUT_WIDTH-1:0];
  assign out_first  = (r_state == SEND) && (r_idx == '0);
  assign out_last   = (r_state == SEND) && w_last;
  assign out_ctrl   = r_ctrl;
  assign hdr_err    = r_hdr_err;
  assign err_cnt    = r_err_cnt;

endmodule
